// File: rtl/sht40_pkg.sv
// rtl/sht40_pkg.sv - shared types, default constants and rounding helper for sht40_convert
package sht40_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL_T  = 2'd1,
        MUL_RH = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int T_SCALE_DEF   = 17500;
    localparam int T_OFFSET_DEF  = -4500;
    localparam int RH_SCALE_DEF  = 12500;
    localparam int RH_OFFSET_DEF = -600;
    localparam int RH_MAX_DEF    = 10000;

    localparam int ROUND_CONST = 32768;
    localparam int RAW_W       = 16;
    localparam int PROD_W      = 32;
    localparam int CALC_W      = 18;
    localparam int OUT_W       = 16;
    localparam int ERR_W       = 8;

    // Round-to-nearest of a 16.16 product down to its integer part.
    function automatic logic [16:0] round_hi(input logic [31:0] p);
        logic [32:0] s;
        s = {1'b0, p} + 33'(ROUND_CONST);
        return s[32:16];
    endfunction

endpackage

// File: rtl/sht40_convert_if.sv
// rtl/sht40_convert_if.sv - raw-word input and converted-result output bundle
interface sht40_convert_if;
    logic [15:0] Temperature_Raw;
    logic        Temp_Ready;
    logic [15:0] Humidity_Raw;
    logic        RH_Ready;
    logic        CRC_Error;
    logic [15:0] Temp_Centi_C;
    logic [15:0] RH_Centi_Pct;
    logic        Result_Valid;
    logic        Busy;
    logic [7:0]  Error_Count;

    modport master (
        output Temperature_Raw, Temp_Ready, Humidity_Raw, RH_Ready, CRC_Error,
        input  Temp_Centi_C, RH_Centi_Pct, Result_Valid, Busy, Error_Count
    );

    modport slave (
        input  Temperature_Raw, Temp_Ready, Humidity_Raw, RH_Ready, CRC_Error,
        output Temp_Centi_C, RH_Centi_Pct, Result_Valid, Busy, Error_Count
    );
endinterface

// File: rtl/seq_mult16.sv
// rtl/seq_mult16.sv - unsigned 16x16 shift-add multiplier, one partial product per cycle
module seq_mult16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    logic [31:0] mcand;
    logic [31:0] acc;
    logic [15:0] mplier;
    logic [3:0]  cnt;

    // product is the accumulator after the current step; valid as a result only while done is high,
    // which lets the caller capture it and restart on the same edge
    always_comb begin
        product = acc + (mplier[0] ? mcand : 32'd0);
        done    = busy && (cnt == 4'd15);
    end

    // Load on start, then add one shifted partial product per cycle for 16 cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {16'd0, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 4'd1;
            if (cnt == 4'd15) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/sht40_convert.sv
// rtl/sht40_convert.sv - raw SHT40 words to clamped centi-unit temperature and humidity
module sht40_convert
    import sht40_pkg::*;
#(
    parameter int T_SCALE   = T_SCALE_DEF,
    parameter int T_OFFSET  = T_OFFSET_DEF,
    parameter int RH_SCALE  = RH_SCALE_DEF,
    parameter int RH_OFFSET = RH_OFFSET_DEF,
    parameter int RH_MAX    = RH_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    sht40_convert_if.slave bus
);
    state_t state, state_next;

    logic              t_rdy_q, rh_rdy_q, t_rise, rh_rise, crc_drop;
    logic              pend_t, pend_rh;
    logic [RAW_W-1:0]  pend_t_word, pend_rh_word, work_rh;
    logic [PROD_W-1:0] p_t, p_rh;
    logic              take, mult_start, cap_t, cap_rh, finish;
    logic [RAW_W-1:0]  mult_a, mult_b;
    logic              mult_busy, mult_done;
    logic [PROD_W-1:0] mult_product;
    logic signed [CALC_W-1:0] t_val, rh_val;
    logic [OUT_W-1:0]  rh_clamped, temp_q, rh_q;
    logic              valid_q, busy_q;
    logic [ERR_W-1:0]  err_q;

    assign bus.Temp_Centi_C = temp_q;
    assign bus.RH_Centi_Pct = rh_q;
    assign bus.Result_Valid = valid_q;
    assign bus.Busy         = busy_q;
    assign bus.Error_Count  = err_q;

    // Rising-edge detection of both ready strobes; CRC on either edge drops the whole frame
    always_comb begin
        t_rise   = bus.Temp_Ready & ~t_rdy_q;
        rh_rise  = bus.RH_Ready & ~rh_rdy_q;
        crc_drop = (t_rise | rh_rise) & bus.CRC_Error;
    end

    // Pending capture: a new edge sets (and overwrites) its channel, taking the pair clears both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_rdy_q      <= 1'b0;
            rh_rdy_q     <= 1'b0;
            pend_t       <= 1'b0;
            pend_rh      <= 1'b0;
            pend_t_word  <= '0;
            pend_rh_word <= '0;
            err_q        <= '0;
        end else begin
            t_rdy_q  <= bus.Temp_Ready;
            rh_rdy_q <= bus.RH_Ready;
            if (crc_drop) begin
                pend_t  <= 1'b0;
                pend_rh <= 1'b0;
                if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            end else begin
                if (take) begin
                    pend_t  <= 1'b0;
                    pend_rh <= 1'b0;
                end
                if (t_rise) begin
                    pend_t      <= 1'b1;
                    pend_t_word <= bus.Temperature_Raw;
                end
                if (rh_rise) begin
                    pend_rh      <= 1'b1;
                    pend_rh_word <= bus.Humidity_Raw;
                end
            end
        end
    end

    seq_mult16 u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mult_start),
        .a       (mult_a),
        .b       (mult_b),
        .busy    (mult_busy),
        .done    (mult_done),
        .product (mult_product)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and multiplier sequencing; the RH multiply starts on the edge the T product is taken
    always_comb begin
        state_next = state;
        take       = 1'b0;
        mult_start = 1'b0;
        mult_a     = pend_t_word;
        mult_b     = 16'(T_SCALE);
        cap_t      = 1'b0;
        cap_rh     = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend_t && pend_rh && !mult_busy) begin
                    take       = 1'b1;
                    mult_start = 1'b1;
                    state_next = MUL_T;
                end
            end
            MUL_T: begin
                mult_a = work_rh;
                mult_b = 16'(RH_SCALE);
                if (mult_done) begin
                    cap_t      = 1'b1;
                    mult_start = 1'b1;
                    state_next = MUL_RH;
                end
            end
            MUL_RH: begin
                if (mult_done) begin
                    cap_rh     = 1'b1;
                    state_next = FINISH;
                end
            end
            FINISH: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Rounding, offset and humidity clamp; temperature range needs no clamp
    always_comb begin
        t_val  = $signed({1'b0, round_hi(p_t)}) + $signed(18'(T_OFFSET));
        rh_val = $signed({1'b0, round_hi(p_rh)}) + $signed(18'(RH_OFFSET));
        if (rh_val < 0)                             rh_clamped = '0;
        else if (rh_val > $signed(18'(RH_MAX)))     rh_clamped = 16'(RH_MAX);
        else                                        rh_clamped = 16'(rh_val);
    end

    // Working registers, products and the result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_rh <= '0;
            p_t     <= '0;
            p_rh    <= '0;
            temp_q  <= '0;
            rh_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (take) begin
                work_rh <= pend_rh_word;
                busy_q  <= 1'b1;
            end
            if (cap_t)  p_t  <= mult_product;
            if (cap_rh) p_rh <= mult_product;
            if (finish) begin
                temp_q  <= 16'(t_val);
                rh_q    <= rh_clamped;
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sht40_convert.sv
// tb/tb_sht40_convert.sv - randomized self-checking bench for sht40_convert
module tb_sht40_convert;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    sht40_convert_if bus ();

    sht40_convert dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ref_t(input int raw);
        longint p;
        p = longint'(raw) * 17500;
        return int'((p + 32768) / 65536) - 4500;
    endfunction

    function automatic int ref_rh(input int raw);
        longint p;
        int v;
        p = longint'(raw) * 12500;
        v = int'((p + 32768) / 65536) - 600;
        if (v < 0) v = 0;
        if (v > 10000) v = 10000;
        return v;
    endfunction

    task automatic send_pair(input logic [15:0] t, input logic [15:0] rh, input int gap,
                             output int lat, output bit busy_seen);
        @(negedge clk);
        bus.Temperature_Raw = t;
        bus.Temp_Ready = 1'b1;
        if (gap == 0) begin
            bus.Humidity_Raw = rh;
            bus.RH_Ready = 1'b1;
        end else begin
            @(negedge clk);
            bus.Temp_Ready = 1'b0;
            repeat (gap - 1) @(negedge clk);
            bus.Humidity_Raw = rh;
            bus.RH_Ready = 1'b1;
        end
        lat = -1;
        busy_seen = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            bus.Temp_Ready = 1'b0;
            bus.RH_Ready = 1'b0;
            if (i == 2 && bus.Busy === 1'b1) busy_seen = 1'b1;
            if (bus.Result_Valid === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    task automatic check_pair(input string name, input logic [15:0] t, input logic [15:0] rh,
                              input int gap);
        int lat;
        bit bs;
        int exp_t, exp_rh;
        exp_t  = ref_t(int'(t));
        exp_rh = ref_rh(int'(rh));
        send_pair(t, rh, gap, lat, bs);
        checks++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL %s latency: got %0d expected 34", name, lat);
        end
        checks++;
        if (bs !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_during: got %0b expected 1", name, bs);
        end
        checks++;
        if (int'($signed(bus.Temp_Centi_C)) !== exp_t) begin
            errors++;
            $display("FAIL %s temp: got %0d expected %0d (raw %h)", name,
                     $signed(bus.Temp_Centi_C), exp_t, t);
        end
        checks++;
        if (int'(bus.RH_Centi_Pct) !== exp_rh) begin
            errors++;
            $display("FAIL %s rh: got %0d expected %0d (raw %h)", name, bus.RH_Centi_Pct, exp_rh, rh);
        end
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_valid: got %0b expected 0", name, bus.Busy);
        end
        @(negedge clk);
        checks++;
        if (bus.Result_Valid !== 1'b0) begin
            errors++;
            $display("FAIL %s valid_width: got %0b expected 0", name, bus.Result_Valid);
        end
        checks++;
        if (int'($signed(bus.Temp_Centi_C)) !== exp_t) begin
            errors++;
            $display("FAIL %s temp_hold: got %0d expected %0d", name, $signed(bus.Temp_Centi_C), exp_t);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (bus.Temp_Centi_C !== 16'd0 || bus.RH_Centi_Pct !== 16'd0 || bus.Result_Valid !== 1'b0 ||
            bus.Busy !== 1'b0 || bus.Error_Count !== 8'd0) begin
            errors++;
            $display("FAIL %s: got T=%h RH=%h V=%b B=%b E=%0d expected all zero", name,
                     bus.Temp_Centi_C, bus.RH_Centi_Pct, bus.Result_Valid, bus.Busy, bus.Error_Count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.Temperature_Raw = '0;
        bus.Humidity_Raw = '0;
        bus.Temp_Ready = 1'b0;
        bus.RH_Ready = 1'b0;
        bus.CRC_Error = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_held");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset_released");
    endtask

    task automatic test_directed();
        check_pair("nominal", 16'h6666, 16'h8000, 0);
        checks++;
        if ($signed(bus.Temp_Centi_C) !== 16'sd2500 || bus.RH_Centi_Pct !== 16'd5650) begin
            errors++;
            $display("FAIL nominal_const: got T=%0d RH=%0d expected 2500 5650",
                     $signed(bus.Temp_Centi_C), bus.RH_Centi_Pct);
        end
        check_pair("full_scale_staggered", 16'hFFFF, 16'hFFFF, 10);
        checks++;
        if (bus.Temp_Centi_C !== 16'd13000 || bus.RH_Centi_Pct !== 16'd10000) begin
            errors++;
            $display("FAIL full_scale_const: got T=%0d RH=%0d expected 13000 10000",
                     $signed(bus.Temp_Centi_C), bus.RH_Centi_Pct);
        end
        check_pair("zero", 16'h0000, 16'h0000, 0);
        checks++;
        if ($signed(bus.Temp_Centi_C) !== -16'sd4500 || bus.RH_Centi_Pct !== 16'd0) begin
            errors++;
            $display("FAIL zero_const: got T=%0d RH=%0d expected -4500 0",
                     $signed(bus.Temp_Centi_C), bus.RH_Centi_Pct);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            logic [15:0] t, rh;
            t  = 16'($urandom_range(0, 65535));
            rh = 16'($urandom_range(0, 65535));
            check_pair($sformatf("random%0d", k), t, rh, int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta, rha, tb, rhb;
        int first, second, nseen;
        int t1, r1, t2, r2;
        ta  = 16'($urandom_range(0, 65535));
        rha = 16'($urandom_range(0, 65535));
        tb  = 16'($urandom_range(0, 65535));
        rhb = 16'($urandom_range(0, 65535));
        first = -1; second = -1; nseen = 0;
        t1 = 0; r1 = 0; t2 = 0; r2 = 0;
        @(negedge clk);
        bus.Temperature_Raw = ta;
        bus.Humidity_Raw = rha;
        bus.Temp_Ready = 1'b1;
        bus.RH_Ready = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            if (i == 1 || i == 7) begin
                bus.Temp_Ready = 1'b0;
                bus.RH_Ready = 1'b0;
            end
            if (i == 6) begin
                bus.Temperature_Raw = tb;
                bus.Humidity_Raw = rhb;
                bus.Temp_Ready = 1'b1;
                bus.RH_Ready = 1'b1;
            end
            if (bus.Result_Valid === 1'b1) begin
                nseen++;
                if (nseen == 1) begin
                    first = i - 1; t1 = int'($signed(bus.Temp_Centi_C)); r1 = int'(bus.RH_Centi_Pct);
                end else if (nseen == 2) begin
                    second = i - 1; t2 = int'($signed(bus.Temp_Centi_C)); r2 = int'(bus.RH_Centi_Pct);
                end
            end
        end
        checks++;
        if (first !== 34) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d expected 34", first);
        end
        checks++;
        if (t1 !== ref_t(int'(ta)) || r1 !== ref_rh(int'(rha))) begin
            errors++;
            $display("FAIL b2b_first_values: got %0d/%0d expected %0d/%0d", t1, r1,
                     ref_t(int'(ta)), ref_rh(int'(rha)));
        end
        checks++;
        if (second - first !== 34 || nseen !== 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d (pulses %0d) expected 34 (pulses 2)",
                     second - first, nseen);
        end
        checks++;
        if (t2 !== ref_t(int'(tb)) || r2 !== ref_rh(int'(rhb))) begin
            errors++;
            $display("FAIL b2b_second_values: got %0d/%0d expected %0d/%0d", t2, r2,
                     ref_t(int'(tb)), ref_rh(int'(rhb)));
        end
    endtask

    task automatic test_crc();
        int exp_err;
        bit vseen;
        exp_err = 0;
        vseen = 1'b0;
        checks++;
        if (int'(bus.Error_Count) !== exp_err) begin
            errors++;
            $display("FAIL crc_start_count: got %0d expected %0d", bus.Error_Count, exp_err);
        end
        @(negedge clk);
        bus.Temperature_Raw = 16'h1234;
        bus.Temp_Ready = 1'b1;
        @(negedge clk);
        bus.Temp_Ready = 1'b0;
        repeat (2) @(negedge clk);
        bus.Humidity_Raw = 16'h4321;
        bus.RH_Ready = 1'b1;
        bus.CRC_Error = 1'b1;
        exp_err++;
        @(negedge clk);
        bus.RH_Ready = 1'b0;
        bus.CRC_Error = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (bus.Result_Valid === 1'b1) vseen = 1'b1;
        end
        checks++;
        if (vseen !== 1'b0) begin
            errors++;
            $display("FAIL crc_no_result: got valid=1 expected 0");
        end
        checks++;
        if (int'(bus.Error_Count) !== exp_err) begin
            errors++;
            $display("FAIL crc_count_one: got %0d expected %0d", bus.Error_Count, exp_err);
        end
        bus.RH_Ready = 1'b1;
        @(negedge clk);
        bus.RH_Ready = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (bus.Result_Valid === 1'b1) vseen = 1'b1;
        end
        checks++;
        if (vseen !== 1'b0) begin
            errors++;
            $display("FAIL crc_pending_cleared: got valid=1 expected 0");
        end
        for (int k = 0; k < 260; k++) begin
            @(negedge clk);
            bus.Temp_Ready = 1'b1;
            bus.CRC_Error = 1'b1;
            @(negedge clk);
            bus.Temp_Ready = 1'b0;
            bus.CRC_Error = 1'b0;
            if (exp_err < 255) exp_err++;
            if (bus.Result_Valid === 1'b1) vseen = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (int'(bus.Error_Count) !== exp_err || vseen !== 1'b0) begin
            errors++;
            $display("FAIL crc_saturate: got %0d valid=%0b expected %0d valid=0",
                     bus.Error_Count, vseen, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        bit vseen;
        vseen = 1'b0;
        @(negedge clk);
        bus.Temperature_Raw = 16'h7777;
        bus.Humidity_Raw = 16'h5555;
        bus.Temp_Ready = 1'b1;
        bus.RH_Ready = 1'b1;
        @(negedge clk);
        bus.Temp_Ready = 1'b0;
        bus.RH_Ready = 1'b0;
        repeat (24) @(negedge clk);
        checks++;
        if (bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy_before: got %0b expected 1", bus.Busy);
        end
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset_immediate");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) begin
            @(negedge clk);
            if (bus.Result_Valid === 1'b1) vseen = 1'b1;
        end
        checks++;
        if (vseen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_pulse: got valid=1 expected 0");
        end
        check_pair("after_reset", 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_crc();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
